fetch_stage: RTL and testbench

- Instruction-fetch stage of the 3-stage pipeline. Sits directly upstream of the IF/ID register and feeds its pc_nxt_in, pc_in and instr_in inputs.
- Owns the program counter and drives a single-outstanding request/response instruction-memory port.
- Buffers fetched words in a small FIFO so that downstream stalls do not cause extra memory re-fetch.
- Handles redirects (branch/jump) from execute, including discarding stale in-flight responses.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage and its buffer.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int          FIFO_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous fetch buffer holding {pc, instr} pairs; flush empties it in one edge.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output fetch_entry_t     head
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  // A push into a full buffer is only legal when the head leaves in the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
  assign empty   = (count == '0);
  assign head    = fetch_entry_t'(mem[rd_ptr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, single-outstanding imem port, fetch buffer, redirect handling.
// Optional macro FETCH_MISALIGN_CHK_EN adds misalign_o and refuses misaligned redirect targets.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_out,
  output logic [31:0] pc_nxt_out,
  output logic [31:0] instr_out,
  output logic        valid_out
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] count;
  logic             empty;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;
  logic             req;
  logic             space;
  logic             target_ok;
  logic [31:0]      target_pc;
  logic             fetch_block;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  assign target_ok   = (redirect_pc_i[1:0] == 2'b00);
  assign target_pc   = redirect_pc_i;
  assign fetch_block = misalign_q;
  assign misalign_o  = misalign_q;

  // Sticky until a well-aligned redirect replaces the bad target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= !target_ok;
    end
  end
`else
  logic [1:0] unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc_i[1:0];
  assign target_ok     = 1'b1;
  assign target_pc     = {redirect_pc_i[31:2], 2'b00};
  assign fetch_block   = 1'b0;
`endif

  // Only one word is ever in flight, and requests leave only from IDLE, so this covers it.
  assign space = (count < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && !redirect_i && space && !fetch_block) begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          push      = !redirect_i;
          state_nxt = IDLE;
        end else if (redirect_i) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      if (target_ok) begin
        fetch_pc <= target_pc;
      end
    end else if (push) begin
      fetch_pc <= pc_plus4(fetch_pc);
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = imem_rdata_i;
  assign pop              = !empty && !stall_i && !redirect_i;

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_i),
    .count    (count),
    .empty    (empty),
    .head     (head)
  );

  // The buffer head is shown directly; a redirect cycle is forced to a bubble.
  always_comb begin
    pc_out     = 32'h0;
    pc_nxt_out = 32'h0;
    instr_out  = NOP_INSTR;
    valid_out  = 1'b0;
    if (!empty && !redirect_i) begin
      pc_out     = head.pc;
      pc_nxt_out = pc_plus4(head.pc);
      instr_out  = head.instr;
      valid_out  = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of the fetch pipeline.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_out;
  logic [31:0] pc_nxt_out;
  logic [31:0] instr_out;
  logic        valid_out;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  // Model: expected buffer contents, next fetch address, in-flight/stale flags.
  logic [63:0] modelQ[$];
  logic [31:0] modelPc;
  bit          modelOut;
  bit          modelStale;
  bit          modelMis;
  bit          expReq;

  // Memory: one pending response with a random latency of 1..3 cycles.
  bit          memPend;
  int          memCnt;
  logic [31:0] memAddr;
  bit          sawReq;
  logic [31:0] sawAddr;
  bit          midReset = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_out       (pc_out),
    .pc_nxt_out   (pc_nxt_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    modelPc    = RST_PC;
    modelOut   = 0;
    modelStale = 0;
    modelMis   = 0;
    memPend    = 0;
    memCnt     = 0;
  endtask

  // Asserts reset mid-cycle, checks the immediate reset values, releases just after an edge.
  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    #1;
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_pc", pc_out, 0);
    checkOutput("rst_pc_nxt", pc_nxt_out, 0);
    checkOutput("rst_instr", instr_out, NOP);
    checkOutput("rst_req", imem_req_o, 0);
    checkOutput("rst_addr", imem_addr_o, RST_PC);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("rst_misalign", misalign_o, 0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    resetModel();
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    stall_i    = ($urandom_range(0, 9) < 3);
    redirect_i = ($urandom_range(0, 99) < 6);
    case ($urandom_range(0, 7))
      0:       redirect_pc_i = 32'hFFFF_FFF8;
      1:       redirect_pc_i = 32'h0000_0100;
      2:       redirect_pc_i = $urandom();
      default: redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
    endcase
    imem_rvalid_i = memPend && (memCnt == 0);
    imem_rdata_i  = imem_rvalid_i ? memWord(memAddr) : $urandom();
  endtask

  task automatic checkCycle();
    logic        eVal;
    logic [31:0] ePc;
    logic [31:0] eNxt;
    logic [31:0] eIns;
    #1;
    eVal = (modelQ.size() > 0) && !redirect_i;
    ePc  = eVal ? modelQ[0][63:32] : 32'h0;
    eNxt = eVal ? modelQ[0][63:32] + 32'd4 : 32'h0;
    eIns = eVal ? modelQ[0][31:0] : NOP;
    expReq = !modelOut && (modelQ.size() < DEPTH) && !redirect_i && !modelMis;
    checkOutput("valid_out", valid_out, eVal);
    checkOutput("pc_out", pc_out, ePc);
    checkOutput("pc_nxt_out", pc_nxt_out, eNxt);
    checkOutput("instr_out", instr_out, eIns);
    checkOutput("imem_req_o", imem_req_o, expReq);
    if (expReq) checkOutput("imem_addr_o", imem_addr_o, modelPc);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("misalign_o", misalign_o, modelMis);
`endif
    sawReq  = imem_req_o;
    sawAddr = imem_addr_o;
  endtask

  task automatic updateModel();
    if (redirect_i) begin
      modelQ.delete();
      if (imem_rvalid_i) begin
        modelOut   = 0;
        modelStale = 0;
      end else if (modelOut) begin
        modelStale = 1;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        modelMis = 1;
      end else begin
        modelMis = 0;
        modelPc  = redirect_pc_i;
      end
`else
      modelPc = redirect_pc_i & 32'hFFFF_FFFC;
`endif
    end else begin
      if ((modelQ.size() > 0) && !stall_i) void'(modelQ.pop_front());
      if (imem_rvalid_i) begin
        if (!modelStale) begin
          modelQ.push_back({modelPc, memWord(modelPc)});
          modelPc = modelPc + 32'd4;
        end
        modelOut   = 0;
        modelStale = 0;
      end
    end
    if (expReq) modelOut = 1;
    if (imem_rvalid_i) memPend = 0;
    else if (memPend) memCnt--;
    if (sawReq) begin
      memPend = 1;
      memCnt  = $urandom_range(0, 2);
      memAddr = sawAddr;
    end
  endtask

  initial begin
    rst           = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    resetModel();
    doReset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!midReset && (cyc >= 2000) && modelOut && !modelStale) begin
        doReset();
        midReset = 1;
      end
      applyStimulus();
      checkCycle();
      @(posedge clk);
      updateModel();
    end
    if (!midReset) checkOutput("mid_wait_reset_reached", 0, 1);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
